// File: rtl/nandgame_pkg.sv
// Shared NandGame+ encoding definitions: request kinds, fixed helper words and
// ALU instruction field positions (shared with the core's decode).
package nandgame_pkg;

  typedef enum logic [1:0] {
    KIND_IMM   = 2'b00,
    KIND_ALU   = 2'b01,
    KIND_IMM_D = 2'b10,
    KIND_RSVD  = 2'b11
  } kind_e;

  typedef struct packed {
    logic       sm;
    logic       u;
    logic [1:0] op;
    logic       zx;
    logic       sw;
  } alu_ctrl_t;

  localparam logic [15:0] NOT_A_WORD   = 16'hE360;
  localparam logic [15:0] MOV_D_A_WORD = 16'hE490;

  localparam int unsigned CI_BIT  = 15;
  localparam int unsigned SM_BIT  = 12;
  localparam int unsigned U_BIT   = 10;
  localparam int unsigned OP_LSB  = 8;
  localparam int unsigned ZX_BIT  = 7;
  localparam int unsigned SW_BIT  = 6;
  localparam int unsigned DST_LSB = 3;
  localparam int unsigned JMP_LSB = 0;

endpackage

// File: rtl/alu_word_pack.sv
// Packs ALU control, destination and jump fields into a 16-bit C-form instruction.
module alu_word_pack
  import nandgame_pkg::*;
(
  input  logic [5:0]  ctrl,
  input  logic [2:0]  dst,
  input  logic [2:0]  jmp,
  output logic [15:0] word
);

  alu_ctrl_t c;

  assign c = alu_ctrl_t'(ctrl);

  always_comb begin
    word = '0;
    word[CI_BIT]           = 1'b1;
    word[14:13]            = 2'b11;
    word[SM_BIT]           = c.sm;
    word[U_BIT]            = c.u;
    word[OP_LSB +: 2]      = c.op;
    word[ZX_BIT]           = c.zx;
    word[SW_BIT]           = c.sw;
    word[DST_LSB +: 3]     = dst;
    word[JMP_LSB +: 3]     = jmp;
  end

endmodule

// File: rtl/instr_encoder.sv
// Turns structured op requests into NandGame+ machine words with sequential
// program addresses; high immediates expand into a ~imm / NOT A pair.
module instr_encoder
  import nandgame_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [15:0]       req_imm,
  input  logic [5:0]        req_ctrl,
  input  logic [2:0]        req_dst,
  input  logic [2:0]        req_jmp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              err,
  output logic              wrapped
);

  typedef enum logic [1:0] {IDLE, EMIT_NOT, EMIT_MOV} state_e;

  state_e            state, state_nxt;
  kind_e             kind;
  logic [15:0]       alu_word;
  logic [15:0]       load_word;
  logic [ADDR_W-1:0] cnt;
  logic              accept, drain, stage_free, load;
  logic              is_d, is_d_nxt, set_err;

  alu_word_pack u_alu_word_pack (
    .ctrl (req_ctrl),
    .dst  (req_dst),
    .jmp  (req_jmp),
    .word (alu_word)
  );

  assign kind       = kind_e'(req_kind);
  assign drain      = out_valid && out_ready;
  assign stage_free = !out_valid || out_ready;
  assign req_ready  = (state == IDLE) && stage_free;
  assign accept     = req_valid && req_ready;
  assign busy       = (state != IDLE) || out_valid;

  // State names the word still to be emitted; EMIT_* only advance when the
  // word currently in the stage is taken, so the next one loads back-to-back.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_word = '0;
    is_d_nxt  = is_d;
    set_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (kind)
            KIND_IMM, KIND_IMM_D: begin
              load      = 1'b1;
              load_word = req_imm[15] ? ~req_imm : req_imm;
              is_d_nxt  = (kind == KIND_IMM_D);
              if (req_imm[15])
                state_nxt = EMIT_NOT;
              else if (kind == KIND_IMM_D)
                state_nxt = EMIT_MOV;
            end
            KIND_ALU: begin
              load      = 1'b1;
              load_word = alu_word;
            end
            KIND_RSVD: set_err = 1'b1;
          endcase
        end
      end
      EMIT_NOT: begin
        if (drain) begin
          load      = 1'b1;
          load_word = NOT_A_WORD;
          state_nxt = is_d ? EMIT_MOV : IDLE;
        end
      end
      EMIT_MOV: begin
        if (drain) begin
          load      = 1'b1;
          load_word = MOV_D_A_WORD;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_d      <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_addr  <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      state <= state_nxt;
      is_d  <= is_d_nxt;
      if (set_err)
        err <= 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_word  <= load_word;
        out_addr  <= cnt;
        cnt       <= cnt + ADDR_W'(1);
        if (cnt == '1)
          wrapped <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (base_load && !busy && !accept) begin
        cnt     <= base_addr;
        wrapped <= 1'b0;
      end
    end
  end

endmodule
